// File: rtl/piso_serializer_if.sv
// Parallel-in and serial-out stream bundle for the PISO serializer.
// Handshake: a beat transfers on a rising clk edge where valid && ready; a producer holding valid must keep its data stable until that edge.
interface piso_serializer_if #(
  parameter int DATA_WID = 8,
  parameter int WORDS    = 4
);
  localparam int TOTAL = DATA_WID * WORDS;

  logic [TOTAL-1:0] par_data;
  logic             par_valid;
  logic             par_ready;
  logic             ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             busy;

  // The environment side: drives frames in and accepts serial bits.
  modport master (
    output par_data, par_valid, ser_ready,
    input  par_ready, ser_data, ser_valid, ser_last, busy
  );

  // The serializer side.
  modport slave (
    input  par_data, par_valid, ser_ready,
    output par_ready, ser_data, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: takes a TOTAL-bit frame and emits it LSB first,
// one bit per accepted serial cycle, flagging the final bit with ser_last.
module piso_serializer #(
  parameter  int DATA_WID = 8,
  parameter  int WORDS    = 4,
  localparam int TOTAL    = DATA_WID * WORDS,
  localparam int CNT_WID  = $clog2(TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  piso_serializer_if.slave   bus,
  output logic               state_o,
  output logic [CNT_WID-1:0] cnt_o
);
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [CNT_WID-1:0] LAST_CNT = CNT_WID'(TOTAL - 1);

  state_e             state_q, state_d;
  logic [TOTAL-1:0]   shreg_q, shreg_d;
  logic [CNT_WID-1:0] cnt_q, cnt_d;
  logic               last;
  logic               par_ready;
  logic               load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // par_ready reopens on the final accepted bit so back-to-back frames have no bubble.
  always_comb begin
    last      = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    par_ready = (state_q == IDLE) || (last && bus.ser_ready);
    load      = bus.par_valid && par_ready;
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          shreg_d = bus.par_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bus.ser_ready) begin
          shreg_d = {1'b0, shreg_q[TOTAL-1:1]};
          cnt_d   = cnt_q + CNT_WID'(1);
          if (last) begin
            cnt_d = '0;
            if (load) begin
              shreg_d = bus.par_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.par_ready = par_ready;
  assign bus.ser_data  = shreg_q[0];
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_last  = last;
  assign bus.busy      = (state_q == SHIFT);
  assign state_o       = state_q;
  assign cnt_o         = cnt_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: reset, idle, basic frame, backpressure,
// back-to-back frames, blocked load and asynchronous reset mid-frame.
module tb_piso_serializer;
  localparam int DATA_WID = 8;
  localparam int WORDS    = 4;
  localparam int CNT_WID  = 5;

  logic               clk;
  logic               rst_n;
  logic               state_o;
  logic [CNT_WID-1:0] cnt_o;
  int                 n_cmp  = 0;
  int                 n_fail = 0;

  piso_serializer_if #(.DATA_WID(DATA_WID), .WORDS(WORDS)) sif ();

  piso_serializer #(.DATA_WID(DATA_WID), .WORDS(WORDS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (sif.slave),
    .state_o (state_o),
    .cnt_o   (cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present a frame one time unit after an edge; it is captured on the following edge.
  task automatic load_frame(input logic [31:0] f);
    @(posedge clk);
    #1;
    sif.par_data  = f;
    sif.par_valid = 1'b1;
    sif.ser_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b1;
    sif.par_valid = 1'b0;
    sif.par_data  = '0;
    sif.ser_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    n_cmp++; if (sif.ser_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ser_valid got %b exp 0", sif.ser_valid); end
    n_cmp++; if (sif.ser_last !== 1'b0) begin n_fail++; $display("FAIL reset_ser_last got %b exp 0", sif.ser_last); end
    n_cmp++; if (sif.ser_data !== 1'b0) begin n_fail++; $display("FAIL reset_ser_data got %b exp 0", sif.ser_data); end
    n_cmp++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", sif.busy); end
    n_cmp++; if (sif.par_ready !== 1'b1) begin n_fail++; $display("FAIL reset_par_ready got %b exp 1", sif.par_ready); end
    n_cmp++; if (state_o !== 1'b0) begin n_fail++; $display("FAIL reset_state got %b exp 0", state_o); end
    n_cmp++; if (cnt_o !== 5'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cnt_o); end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      n_cmp++; if (sif.ser_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ser_valid cyc %0d got %b exp 0", i, sif.ser_valid); end
      n_cmp++; if (sif.par_ready !== 1'b1) begin n_fail++; $display("FAIL idle_par_ready cyc %0d got %b exp 1", i, sif.par_ready); end
      n_cmp++; if (sif.ser_data !== 1'b0) begin n_fail++; $display("FAIL idle_ser_data cyc %0d got %b exp 0", i, sif.ser_data); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rx;
    rx = '0;
    load_frame(32'h44332211);
    #1;
    n_cmp++; if (sif.par_ready !== 1'b1) begin n_fail++; $display("FAIL basic_load_ready got %b exp 1", sif.par_ready); end
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1 sif.par_valid = 1'b0;
      #1;
      n_cmp++; if (sif.ser_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ser_valid bit %0d got %b exp 1", i, sif.ser_valid); end
      n_cmp++; if (sif.ser_last !== (i == 31)) begin n_fail++; $display("FAIL basic_ser_last bit %0d got %b exp %b", i, sif.ser_last, (i == 31)); end
      n_cmp++; if (sif.par_ready !== (i == 31)) begin n_fail++; $display("FAIL basic_par_ready bit %0d got %b exp %b", i, sif.par_ready, (i == 31)); end
      rx[i] = sif.ser_data;
    end
    n_cmp++; if (rx[7:0] !== 8'b0001_0001) begin n_fail++; $display("FAIL basic_first_byte got %b exp 00010001", rx[7:0]); end
    n_cmp++; if (rx !== 32'h44332211) begin n_fail++; $display("FAIL basic_frame got %h exp 44332211", rx); end
    @(posedge clk);
    #2;
    n_cmp++; if (sif.ser_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid got %b exp 0", sif.ser_valid); end
    n_cmp++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL basic_end_busy got %b exp 0", sif.busy); end
    n_cmp++; if (sif.par_ready !== 1'b1) begin n_fail++; $display("FAIL basic_end_ready got %b exp 1", sif.par_ready); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rx;
    int          acc;
    int          stall;
    logic        done;
    rx    = '0;
    acc   = 0;
    stall = 0;
    done  = 1'b0;
    load_frame(32'hA5A5A5A5);
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk);
      #1;
      sif.par_valid = 1'b0;
      sif.ser_ready = !(acc == 5 && stall < 3);
      #1;
      if (!sif.ser_ready) begin
        stall++;
        n_cmp++; if (sif.ser_data !== 1'b1) begin n_fail++; $display("FAIL bp_hold_data stall %0d got %b exp 1", stall, sif.ser_data); end
        n_cmp++; if (cnt_o !== 5'd5) begin n_fail++; $display("FAIL bp_hold_cnt stall %0d got %0d exp 5", stall, cnt_o); end
        n_cmp++; if (sif.ser_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid stall %0d got %b exp 1", stall, sif.ser_valid); end
      end else begin
        if (acc == 6) begin
          n_cmp++; if (sif.ser_data !== 1'b0) begin n_fail++; $display("FAIL bp_resume_bit6 got %b exp 0", sif.ser_data); end
        end
        if (sif.ser_valid && acc < 32) begin
          rx[acc] = sif.ser_data;
          acc++;
        end
        if (sif.ser_last) begin
          n_cmp++; if (acc !== 32) begin n_fail++; $display("FAIL bp_accepted got %0d exp 32", acc); end
          done = 1'b1;
        end
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got %b exp 1", done); end
    n_cmp++; if (stall !== 3) begin n_fail++; $display("FAIL bp_stall_cycles got %0d exp 3", stall); end
    n_cmp++; if (rx !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bp_frame got %h exp a5a5a5a5", rx); end
    @(posedge clk);
    #2;
    n_cmp++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL bp_end_busy got %b exp 0", sif.busy); end
  endtask

  task automatic test_back_to_back();
    load_frame(32'hFFFFFFFF);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      sif.par_data  = 32'h00000000;
      sif.par_valid = (i <= 31);
      #1;
      n_cmp++; if (sif.ser_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ser_valid bit %0d got %b exp 1", i, sif.ser_valid); end
      n_cmp++; if (sif.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy bit %0d got %b exp 1", i, sif.busy); end
      n_cmp++; if (sif.ser_data !== (i < 32)) begin n_fail++; $display("FAIL b2b_ser_data bit %0d got %b exp %b", i, sif.ser_data, (i < 32)); end
      n_cmp++; if (sif.ser_last !== (i == 31 || i == 63)) begin n_fail++; $display("FAIL b2b_ser_last bit %0d got %b exp %b", i, sif.ser_last, (i == 31 || i == 63)); end
      n_cmp++; if (sif.par_ready !== (i == 31 || i == 63)) begin n_fail++; $display("FAIL b2b_par_ready bit %0d got %b exp %b", i, sif.par_ready, (i == 31 || i == 63)); end
    end
    @(posedge clk);
    #2;
    n_cmp++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy got %b exp 0", sif.busy); end
  endtask

  task automatic test_blocked_load();
    logic [31:0] rx1;
    logic [31:0] rx2;
    rx1 = '0;
    rx2 = '0;
    load_frame(32'hC3C3C3C3);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      sif.par_valid = (i >= 10 && i <= 31);
      if (i >= 10) sif.par_data = (i <= 31) ? 32'h12345678 : 32'hFFFF0000;
      #1;
      if (i >= 10 && i < 31) begin
        n_cmp++; if (sif.par_ready !== 1'b0) begin n_fail++; $display("FAIL blk_par_ready bit %0d got %b exp 0", i, sif.par_ready); end
      end
      if (i == 31) begin
        n_cmp++; if (sif.par_ready !== 1'b1) begin n_fail++; $display("FAIL blk_last_ready got %b exp 1", sif.par_ready); end
      end
      n_cmp++; if (sif.ser_valid !== 1'b1) begin n_fail++; $display("FAIL blk_ser_valid bit %0d got %b exp 1", i, sif.ser_valid); end
      if (i < 32) rx1[i] = sif.ser_data;
      else        rx2[i-32] = sif.ser_data;
    end
    n_cmp++; if (rx1 !== 32'hC3C3C3C3) begin n_fail++; $display("FAIL blk_frame1 got %h exp c3c3c3c3", rx1); end
    n_cmp++; if (rx2 !== 32'h12345678) begin n_fail++; $display("FAIL blk_frame2 got %h exp 12345678", rx2); end
    @(posedge clk);
    #2;
    n_cmp++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL blk_end_busy got %b exp 0", sif.busy); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rx;
    rx = '0;
    load_frame(32'hFFFFFFFF);
    for (int i = 0; i <= 17; i++) begin
      @(posedge clk);
      #1 sif.par_valid = 1'b0;
      #1;
    end
    n_cmp++; if (sif.ser_data !== 1'b1) begin n_fail++; $display("FAIL arst_pre_data got %b exp 1", sif.ser_data); end
    n_cmp++; if (cnt_o !== 5'd17) begin n_fail++; $display("FAIL arst_pre_cnt got %0d exp 17", cnt_o); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (sif.ser_valid !== 1'b0) begin n_fail++; $display("FAIL arst_ser_valid got %b exp 0", sif.ser_valid); end
    n_cmp++; if (sif.ser_last !== 1'b0) begin n_fail++; $display("FAIL arst_ser_last got %b exp 0", sif.ser_last); end
    n_cmp++; if (sif.ser_data !== 1'b0) begin n_fail++; $display("FAIL arst_ser_data got %b exp 0", sif.ser_data); end
    n_cmp++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", sif.busy); end
    n_cmp++; if (cnt_o !== 5'd0) begin n_fail++; $display("FAIL arst_cnt got %0d exp 0", cnt_o); end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    n_cmp++; if (sif.par_ready !== 1'b1) begin n_fail++; $display("FAIL arst_post_ready got %b exp 1", sif.par_ready); end
    n_cmp++; if (sif.ser_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_replay got %b exp 0", sif.ser_valid); end
    load_frame(32'h000000FF);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1 sif.par_valid = 1'b0;
      #1;
      if (i == 0) begin
        n_cmp++; if (sif.ser_data !== 1'b1) begin n_fail++; $display("FAIL arst_first_bit got %b exp 1", sif.ser_data); end
      end
      rx[i] = sif.ser_data;
    end
    n_cmp++; if (rx !== 32'h000000FF) begin n_fail++; $display("FAIL arst_frame got %h exp 000000ff", rx); end
    @(posedge clk);
    #2;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_blocked_load();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
